mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Multicycle HI/LO multiply/divide unit in the Execute stage of the pipelined MIPS CPU.
//   Executes mult/multu/div/divu with parametrised latency, plus mthi/mtlo.
//   Holds HI/LO for mfhi/mflo.
//   Drives a busy/stall request that the hazard unit combines with the D-stage MD-use decode.
//   A cancel input aborts an in-flight operation when an instruction is squashed.
// PARAMETERS
//   WIDTH     32  operand width; HI and LO are WIDTH bits each
//   MULT_LAT   5  cycles busy stays high for mult/multu (>=1)
//   DIV_LAT   10  cycles busy stays high for div/divu (>=1)
//   CNT_W      4  counter width; must satisfy 2**CNT_W > max(MULT_LAT,DIV_LAT)
// PORTS
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-high; clears all state
//   start     in   1        E-stage instr is an MD op this cycle (one-cycle pulse per instr)
//   md_op     in   3        op code, encodings from the shared MD package
//   a         in   WIDTH    rs value (forwarded)
//   b         in   WIDTH    rt value (forwarded)
//   cancel    in   1        abort in-flight op (squash)
//   busy      out  1        registered; op in flight
//   md_stall  out  1        comb: busy | (start & md_op is mult/multu/div/divu)
//   hi        out  WIDTH    HI register
//   lo        out  WIDTH    LO register
// BEHAVIOUR
//   Reset: busy=0, hi=0, lo=0, counter=0, pending regs=0, state IDLE. Async assert, sync release.
//   States:
//     IDLE --start & MUL/DIV op--> RUN
//     RUN --counter==1--> IDLE (commit)
//     RUN --cancel--> IDLE (no commit)
//   Accept (IDLE, start, MUL/DIV op) at edge E0:
//     latch op and operands; counter := LAT; busy := 1.
//     Compute the result from the latched operands.
//   RUN, each edge: counter -= 1.
//     At the edge where counter==1: write hi/lo from the pending result, busy := 0, go IDLE.
//     busy is therefore high for exactly LAT cycles.
//     New hi/lo are visible in the cycle busy first reads 0.
//   mult:  {hi,lo} = $signed(a) * $signed(b), 2*WIDTH bits.
//   multu: {hi,lo} = unsigned product, 2*WIDTH bits.
//   div:   lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//          MIN_INT / -1: lo = MIN_INT, hi = 0.
//   divu:  unsigned quotient and remainder.
//   Divide by zero (div or divu): op is still accepted and busy runs the full DIV_LAT cycles.
//     hi/lo are left UNCHANGED at commit.
//   mthi/mtlo: accepted only in IDLE; single cycle; hi := a or lo := a at the next edge; busy stays 0.
//   start while RUN: ignored; the hazard unit guarantees this never happens.
//     The bench asserts on it.
//   cancel:
//     In RUN: go IDLE, busy := 0 next edge, hi/lo unchanged.
//     In IDLE: no effect, and it blocks a same-cycle start (the op is not accepted).
//   cancel on the commit edge (counter==1): cancel wins, no commit.
//   Reset mid-RUN: everything is cleared; hi/lo := 0.
//   Unknown md_op with start: ignored.
// STRUCTURE
//   Shared package/macros file (same place as the existing opcode macros):
//     MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_NONE=7.
//   Controller decode gains md_start, md_op, and MD-use flags.
//     The hazard unit stalls D when the D instr is MD-class and md_stall=1.
//   Sub-module md_latency_ctr:
//     load/decrement/clear down-counter with a terminal flag.
//     The parent module holds the FSM, the pending result, and HI/LO.
// TESTING
//   1. mult a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   2. multu a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
//   3. div a=-7, b=2 -> busy 10 cycles, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//      divu with b=0 -> hi/lo unchanged.
//   4. mthi a=0x1234 then mtlo a=0x5678 on back-to-back cycles
//      -> hi=0x1234, lo=0x5678, busy never asserted.
//   5. mult started, cancel at busy cycle 3 -> busy drops next edge, hi/lo keep the prior values.
//      Repeat with cancel on the commit cycle -> no commit.
//   6. reset asserted asynchronously mid-div -> busy, hi, lo = 0 immediately.
//      After release, a fresh mult 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared MD opcode encodings, FSM state type and op-class helpers.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NONE  = 3'd7
    } md_op_e;

    typedef enum logic {IDLE, RUN} md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/md_latency_ctr.sv
// md_latency_ctr: loadable down-counter that flags the last busy cycle (count==1).
module md_latency_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_val,
    output logic             term
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;

    assign term = count == CNT_W'(1);

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multicycle HI/LO multiply/divide unit with cancel, busy and stall request.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state;
    md_op_e             op_q;
    logic [WIDTH-1:0]   a_q, b_q, b_s, b_u, sq, sr, uq, ur;
    logic [2*WIDTH-1:0] sprod, uprod, res;
    logic [CNT_W-1:0]   lat;
    logic               run, accept, term, wr, div_ovf, mt_ok;

    assign run      = state == RUN;
    assign accept   = !run && start && !cancel && is_muldiv(md_op);
    assign mt_ok    = !run && start && !cancel;
    assign md_stall = busy | (start & is_muldiv(md_op));
    assign lat      = is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    // Divisors are forced to 1 for /0 (result discarded) and MIN_INT/-1 (1 yields the required MIN_INT, 0).
    always_comb begin
        div_ovf = a_q == MIN_INT && b_q == '1;
        b_s     = (b_q == '0 || div_ovf) ? WIDTH'(1) : b_q;
        b_u     = b_q == '0 ? WIDTH'(1) : b_q;
        sq      = $signed(a_q) / $signed(b_s);
        sr      = $signed(a_q) % $signed(b_s);
        uq      = a_q / b_u;
        ur      = a_q % b_u;
        sprod   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        uprod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        res     = op_q == MD_MULT  ? sprod :
                  op_q == MD_MULTU ? uprod :
                  op_q == MD_DIV   ? {sr, sq} : {ur, uq};
        wr      = !(is_div(op_q) && b_q == '0);
    end

    md_latency_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .dec      (run),
        .clr      (run & (cancel | term)),
        .load_val (lat),
        .term     (term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= MD_MULT;
            a_q   <= '0;
            b_q   <= '0;
        end else if (run) begin
            if (cancel || term) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
            if (!cancel && term && wr)
                {hi, lo} <= res;
        end else if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= md_op_e'(md_op);
            a_q   <= a;
            b_q   <= b;
        end else if (mt_ok && md_op == MD_MTHI) begin
            hi <= a;
        end else if (mt_ok && md_op == MD_MTLO) begin
            lo <= a;
        end
    end

endmodule
